dec3to8_strobe: RTL



---
 rtl/dec_pkg.sv | 21 ++
 rtl/dec3to8_strobe.sv | 112 +++++++++++
 2 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the 3-to-8 strobe decoder.
// Holds the FSM state encoding, counter width and the one-hot helper.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  // Map a 3-bit select code to its single strobe line.
  function automatic logic [7:0] onehot3(input logic [2:0] code);
    logic [7:0] line;
    line = 8'h00;
    line[code] = 1'b1;
    return line;
  endfunction

endpackage

// File: rtl/dec3to8_strobe.sv
// Sequential 3-to-8 decoder: accepts a code via valid/ready, drives its one-hot
// line for PULSE_LEN cycles, then holds the output low for GAP_LEN cycles.
module dec3to8_strobe
  import dec_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  if ((PULSE_LEN < 32'd1) || (PULSE_LEN > 32'd255) || (GAP_LEN > 32'd255)) begin : g_bad_param
    $error("dec3to8_strobe: PULSE_LEN must be 1..255 and GAP_LEN 0..255");
  end

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN == 32'd0) ? {CNT_W{1'b0}}
                                                               : CNT_W'(GAP_LEN - 32'd1);
  localparam logic             HAS_GAP    = (GAP_LEN != 32'd0);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       code_r;
  logic             cnt_zero_s;

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // Ready is gated by rst_n so it reads low for the whole time reset is held.
  assign in_ready = rst_n && en && (state_r == IDLE);

  // Decoder FSM with pulse/gap down-counter and registered strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      code_r  <= 3'd0;
      y       <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!en) begin
      // Abort: drop straight to IDLE without signalling completion.
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      y       <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            state_r <= DRIVE;
            code_r  <= in_code;
            cnt_r   <= PULSE_LOAD;
            y       <= onehot3(in_code);
            busy    <= 1'b1;
          end else begin
            y    <= 8'h00;
            busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt_zero_s) begin
            y    <= 8'h00;
            done <= 1'b1;
            if (HAS_GAP) begin
              state_r <= GAP;
              cnt_r   <= GAP_LOAD;
              busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              cnt_r   <= {CNT_W{1'b0}};
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
            y     <= onehot3(code_r);
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        GAP: begin
          done <= 1'b0;
          y    <= 8'h00;
          if (cnt_zero_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          y       <= 8'h00;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
